// File: rtl/siso_frame_loader_if.sv
// ---------------------------------------------------------------------------
// siso_frame_loader_if
//   Bundles the siso_frame_loader frame input, read port and status signals.
//   The producer/decoder side takes the master modport. The loader takes the
//   slave modport.
//
//   Frame input (master -> slave):
//     blklen[15:0], valid_blklen      block length K and its one-cycle strobe
//     in[LLR_W], valid_in             interleaved sys/parity LLR stream
//     apriori[LLR_W], valid_apriori   a-priori LLR stream (independent valid)
//     release_req                     decoder has finished with the frame
//   Read port:
//     rd_en, rd_addr[ADDR_W]          request (master -> slave)
//     rd_sys, rd_par, rd_apriori,
//     rd_valid                        response, one cycle later (slave -> master)
//   Status (slave -> master):
//     frame_len[15:0], busy, frame_done, err_blklen, err_overrun
//
//   "release" is a SystemVerilog keyword, so the release strobe is carried
//   as release_req.
// ---------------------------------------------------------------------------
interface siso_frame_loader_if #(
  parameter int LLR_W  = 16,
  parameter int ADDR_W = 13
);
  logic        [15:0]       blklen;
  logic                     valid_blklen;
  logic signed [LLR_W-1:0]  in;
  logic                     valid_in;
  logic signed [LLR_W-1:0]  apriori;
  logic                     valid_apriori;
  logic                     release_req;
  logic                     rd_en;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [LLR_W-1:0]  rd_sys;
  logic signed [LLR_W-1:0]  rd_par;
  logic signed [LLR_W-1:0]  rd_apriori;
  logic                     rd_valid;
  logic        [15:0]       frame_len;
  logic                     busy;
  logic                     frame_done;
  logic                     err_blklen;
  logic                     err_overrun;

  modport master (
    output blklen, valid_blklen, in, valid_in, apriori, valid_apriori,
           release_req, rd_en, rd_addr,
    input  rd_sys, rd_par, rd_apriori, rd_valid, frame_len, busy,
           frame_done, err_blklen, err_overrun
  );

  modport slave (
    input  blklen, valid_blklen, in, valid_in, apriori, valid_apriori,
           release_req, rd_en, rd_addr,
    output rd_sys, rd_par, rd_apriori, rd_valid, frame_len, busy,
           frame_done, err_blklen, err_overrun
  );
endinterface

// File: rtl/siso_frame_loader.sv
// ---------------------------------------------------------------------------
// siso_frame_loader
//   Input framing/buffer stage in front of the SISO decoder core. It accepts a
//   block length K, checks it against the LTE turbo interleaver size table,
//   then stores one frame:
//     - an interleaved stream of 2*(K+TAIL_LEN) samples, where even samples
//       are systematic LLRs and odd samples are parity LLRs of bit n>>1;
//     - K a-priori LLRs arriving on an independent stream.
//   Once both streams are complete the frame is held (FULL) and served to the
//   decoder by random-access reads until the decoder releases it.
//
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset (state, counters, status outputs;
//          RAM contents are kept)
//     bus  siso_frame_loader_if.slave (frame input, read port, status)
//
//   Optional feature, macro SISO_FRAME_LOADER_SAT_EN:
//     defined   - in/apriori are saturated to signed SAT_W before storage and
//                 sign-extended back to LLR_W on read.
//     undefined - LLRs are stored and returned verbatim; SAT_W only has to
//                 be a sane value.
// ---------------------------------------------------------------------------
module siso_frame_loader #(
  parameter int LLR_W      = 16,
  parameter int MAX_BLKLEN = 6144,
  parameter int TAIL_LEN   = 3,
  parameter int ADDR_W     = $clog2(MAX_BLKLEN + TAIL_LEN),
  parameter int SAT_W      = 8
) (
  input logic               clk,
  input logic               rst,
  siso_frame_loader_if.slave bus
);

  localparam int DEPTH = MAX_BLKLEN + TAIL_LEN;

`ifdef SISO_FRAME_LOADER_SAT_EN
  localparam int STORE_W = SAT_W;
  localparam logic signed [LLR_W-1:0] SAT_HI = LLR_W'((2 ** (SAT_W - 1)) - 1);
  localparam logic signed [LLR_W-1:0] SAT_LO = LLR_W'(-(2 ** (SAT_W - 1)));
`else
  localparam int STORE_W = LLR_W;
`endif

  if (SAT_W < 2 || SAT_W > LLR_W) begin : g_sat_w_check
    $error("siso_frame_loader: SAT_W must lie in 2..LLR_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } state_t;

  // LTE turbo interleaver sizes: 40..512/8, 528..1024/16, 1056..2048/32,
  // 2112..6144/64, further capped by MAX_BLKLEN.
  function automatic logic blklen_legal(input logic [15:0] k);
    logic ok;
    ok = 1'b0;
    if (k >= 16'd40 && k <= 16'd512)        ok = (k[2:0] == 3'd0);
    else if (k >= 16'd528 && k <= 16'd1024)  ok = (k[3:0] == 4'd0);
    else if (k >= 16'd1056 && k <= 16'd2048) ok = (k[4:0] == 5'd0);
    else if (k >= 16'd2112 && k <= 16'd6144) ok = (k[5:0] == 6'd0);
    if (int'(k) > MAX_BLKLEN) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic signed [STORE_W-1:0] sat_llr(input logic signed [LLR_W-1:0] x);
`ifdef SISO_FRAME_LOADER_SAT_EN
    if (x > SAT_HI)      return SAT_HI[STORE_W-1:0];
    else if (x < SAT_LO) return SAT_LO[STORE_W-1:0];
    else                 return x[STORE_W-1:0];
`else
    return x;
`endif
  endfunction

  function automatic logic signed [LLR_W-1:0] ext_llr(input logic signed [STORE_W-1:0] x);
    return LLR_W'(x);
  endfunction

  state_t state, state_nxt;

  logic        [15:0]       frame_len_q;
  logic        [15:0]       s_cnt;
  logic        [15:0]       a_cnt;
  logic        [15:0]       s_tgt;
  logic                     frame_done_q;
  logic                     err_blklen_q;
  logic                     err_overrun_q;

  logic                     blklen_ok;
  logic                     s_need;
  logic                     a_need;
  logic                     in_acc;
  logic                     apr_acc;
  logic                     load_done;
  logic        [ADDR_W-1:0] wr_idx;
  logic        [ADDR_W-1:0] apr_idx;

  logic signed [STORE_W-1:0] sys_mem [DEPTH];
  logic signed [STORE_W-1:0] par_mem [DEPTH];
  logic signed [STORE_W-1:0] apr_mem [DEPTH];

  logic                     rd_acc_p0;
  logic                     rd_oor_p0;
  logic                     rd_tail_p0;
  logic        [ADDR_W-1:0] rd_idx_p0;

  logic                     vld_p1;
  logic                     oor_p1;
  logic                     tail_p1;
  logic signed [STORE_W-1:0] sys_q_p1;
  logic signed [STORE_W-1:0] par_q_p1;
  logic signed [STORE_W-1:0] apr_q_p1;

  assign blklen_ok = blklen_legal(bus.blklen);

  // Frame is complete once all sys/par samples including the tail and all K
  // a-priori values have been taken, in whichever order they arrived.
  assign s_tgt     = (frame_len_q + 16'(TAIL_LEN)) << 1;
  assign s_need    = (s_cnt < s_tgt);
  assign a_need    = (a_cnt < frame_len_q);
  assign load_done = !s_need && !a_need;

  // Samples beyond what the frame needs are dropped quietly during LOAD.
  assign in_acc  = (state == ST_LOAD) && bus.valid_in && s_need;
  assign apr_acc = (state == ST_LOAD) && bus.valid_apriori && a_need;
  assign wr_idx  = ADDR_W'(s_cnt >> 1);
  assign apr_idx = ADDR_W'(a_cnt);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.valid_blklen && blklen_ok) state_nxt = ST_LOAD;
      ST_LOAD: if (load_done)                      state_nxt = ST_FULL;
      ST_FULL: if (bus.release_req)                state_nxt = ST_IDLE;
      default:                                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_len_q   <= '0;
      s_cnt         <= '0;
      a_cnt         <= '0;
      frame_done_q  <= 1'b0;
      err_blklen_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      frame_done_q  <= (state == ST_LOAD) && load_done;
      // A length outside IDLE is never taken, including on a release cycle.
      err_blklen_q  <= bus.valid_blklen && ((state != ST_IDLE) || !blklen_ok);
      err_overrun_q <= (state == ST_FULL) && bus.valid_in;
      if ((state == ST_IDLE) && bus.valid_blklen && blklen_ok)
        frame_len_q <= bus.blklen;
      if (state_nxt == ST_IDLE) begin
        s_cnt <= '0;
        a_cnt <= '0;
      end else begin
        if (in_acc)  s_cnt <= s_cnt + 16'd1;
        if (apr_acc) a_cnt <= a_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc) begin
      if (!s_cnt[0]) sys_mem[wr_idx] <= sat_llr(bus.in);
      else           par_mem[wr_idx] <= sat_llr(bus.in);
    end
    if (apr_acc) apr_mem[apr_idx] <= sat_llr(bus.apriori);
  end

  // ---- read stage p0: request decode --------------------------------------
  // Out-of-frame addresses read a safe location; the data is masked at p1.
  assign rd_acc_p0  = (state == ST_FULL) && bus.rd_en;
  assign rd_oor_p0  = 32'(bus.rd_addr) >= (32'(frame_len_q) + 32'(TAIL_LEN));
  assign rd_tail_p0 = 32'(bus.rd_addr) >= 32'(frame_len_q);
  assign rd_idx_p0  = rd_oor_p0 ? '0 : bus.rd_addr;

  // ---- read stage p1: registered RAM output ------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      oor_p1  <= 1'b0;
      tail_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_acc_p0;
      oor_p1  <= rd_oor_p0;
      tail_p1 <= rd_tail_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc_p0) begin
      sys_q_p1 <= sys_mem[rd_idx_p0];
      par_q_p1 <= par_mem[rd_idx_p0];
      apr_q_p1 <= apr_mem[rd_idx_p0];
    end
  end

  // The a-priori RAM is never written at tail positions, so the tail reads
  // as zero by masking rather than by clearing memory.
  assign bus.rd_valid   = vld_p1;
  assign bus.rd_sys     = (vld_p1 && !oor_p1)  ? ext_llr(sys_q_p1) : '0;
  assign bus.rd_par     = (vld_p1 && !oor_p1)  ? ext_llr(par_q_p1) : '0;
  assign bus.rd_apriori = (vld_p1 && !tail_p1) ? ext_llr(apr_q_p1) : '0;

  assign bus.frame_len   = frame_len_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.err_blklen  = err_blklen_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_siso_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_siso_frame_loader
//   Directed sequence with randomized frame contents and stream timing. The
//   expected read data is derived from the stimulus arrays by stream position
//   (sys of bit n = sample 2n, parity = sample 2n+1, a-priori only below K).
// ---------------------------------------------------------------------------
module tb_siso_frame_loader;
  localparam int LLR_W      = 16;
  localparam int MAX_BLKLEN = 6144;
  localparam int TAIL_LEN   = 3;
  localparam int ADDR_W     = 13;
  localparam int SAT_W      = 8;
  localparam int MAXS       = 2 * (MAX_BLKLEN + TAIL_LEN);

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cur_k    = 0;

  logic signed [15:0] src_in  [MAXS];
  logic signed [15:0] src_apr [MAX_BLKLEN];

  siso_frame_loader_if #(.LLR_W(LLR_W), .ADDR_W(ADDR_W)) bus ();

  siso_frame_loader #(
    .LLR_W(LLR_W), .MAX_BLKLEN(MAX_BLKLEN), .TAIL_LEN(TAIL_LEN),
    .ADDR_W(ADDR_W), .SAT_W(SAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_k(input int k);
    int lo [4] = '{40, 528, 1056, 2112};
    int hi [4] = '{512, 1024, 2048, 6144};
    int st [4] = '{8, 16, 32, 64};
    for (int i = 0; i < 4; i++)
      if (k >= lo[i] && k <= hi[i] && ((k - lo[i]) % st[i]) == 0)
        return (k <= MAX_BLKLEN);
    return 1'b0;
  endfunction

  function automatic logic signed [15:0] sat_m(input logic signed [15:0] v);
`ifdef SISO_FRAME_LOADER_SAT_EN
    int hi;
    hi = (2 ** (SAT_W - 1)) - 1;
    if (int'(v) > hi)      return 16'(hi);
    if (int'(v) < -hi - 1) return 16'(-hi - 1);
`endif
    return v;
  endfunction

  function automatic logic [63:0] exp_rd(input int a);
    logic signed [15:0] s, p, r;
    s = '0; p = '0; r = '0;
    if (a < cur_k + TAIL_LEN) begin
      s = sat_m(src_in[2*a]);
      p = sat_m(src_in[2*a+1]);
      if (a < cur_k) r = sat_m(src_apr[a]);
    end
    return {15'b0, 1'b1, s, p, r};
  endfunction

  function automatic logic [63:0] obs_rd();
    return {15'b0, bus.rd_valid, bus.rd_sys, bus.rd_par, bus.rd_apriori};
  endfunction

  function automatic logic [63:0] obs_status();
    return {43'b0, bus.frame_len, bus.rd_valid, bus.busy, bus.frame_done,
            bus.err_blklen, bus.err_overrun};
  endfunction

  task automatic idle_inputs();
    bus.blklen = '0; bus.valid_blklen = 1'b0;
    bus.in = '0; bus.valid_in = 1'b0;
    bus.apriori = '0; bus.valid_apriori = 1'b0;
    bus.release_req = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic gen(input int k, input bit rnd);
    for (int s = 0; s < 2 * (k + TAIL_LEN); s++) src_in[s] = rnd ? 16'($urandom) : 16'(s);
    for (int a = 0; a < k; a++) src_apr[a] = rnd ? 16'($urandom) : 16'(1000 + a);
  endtask

  task automatic send_blklen(input int k, input bit exp_err, input bit exp_busy, input string tag);
    bus.blklen = 16'(k); bus.valid_blklen = 1'b1;
    step();
    bus.valid_blklen = 1'b0;
    chk($sformatf("%s_err", tag), 64'(bus.err_blklen), 64'(exp_err));
    chk($sformatf("%s_busy", tag), 64'(bus.busy), 64'(exp_busy));
    step();
    chk($sformatf("%s_errpulse", tag), 64'(bus.err_blklen), 64'd0);
  endtask

  task automatic load_frame(input int k, input bit in_rand, input int apr_every,
                            input int apr_lag, input bit extra_apr, input string tag);
    int si = 0, ai = 0, cyc = 0, pulses = 0;
    int tgt = 2 * (k + TAIL_LEN);
    bit early = 1'b0, vi, va;
    while ((si < tgt || ai < k) && cyc < 40000) begin
      vi = (si < tgt) && (!in_rand || $urandom_range(1, 0) == 1);
      va = (cyc >= apr_lag) && ((cyc % apr_every) == 0) && (ai < k || extra_apr);
      bus.valid_in = vi;
      bus.in = vi ? src_in[si] : 16'($urandom);
      bus.valid_apriori = va;
      bus.apriori = (ai < k) ? src_apr[ai] : 16'sh5A5A;
      step();
      if (bus.frame_done) early = 1'b1;
      if (vi) si++;
      if (va && ai < k) ai++;
      cyc++;
    end
    bus.valid_in = 1'b0; bus.valid_apriori = 1'b0;
    chk($sformatf("%s_budget", tag), 64'(cyc < 40000), 64'd1);
    chk($sformatf("%s_early", tag), 64'(early), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.frame_done) pulses++;
    end
    chk($sformatf("%s_pulses", tag), 64'(pulses), 64'd1);
    chk($sformatf("%s_busy", tag), 64'(bus.busy), 64'd1);
  endtask

  task automatic read_one(input int a, input string tag);
    bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(a);
    step();
    bus.rd_en = 1'b0;
    chk(tag, obs_rd(), exp_rd(a));
  endtask

  task automatic read_seq(input int lo, input int hi, input string tag);
    for (int a = lo; a <= hi; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(a);
      step();
      chk($sformatf("%s_%0d", tag, a), obs_rd(), exp_rd(a));
    end
    bus.rd_en = 1'b0;
    step();
    chk($sformatf("%s_end", tag), 64'(bus.rd_valid), 64'd0);
  endtask

  task automatic read_rand(input int n, input string tag);
    int a;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(cur_k + TAIL_LEN + 3, 0);
      read_one(a, $sformatf("%s_%0d", tag, a));
      if ($urandom_range(1, 0) == 1) begin
        step();
        chk($sformatf("%s_gap", tag), 64'(bus.rd_valid), 64'd0);
      end
    end
  endtask

  task automatic release_frame(input string tag);
    bus.release_req = 1'b1;
    step();
    bus.release_req = 1'b0;
    chk($sformatf("%s_busy", tag), 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int k;
    bit lg;
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    chk("reset_status", obs_status(), 64'd0);
    chk("reset_rd", obs_rd(), 64'd0);
    rst = 1'b0;
    step();

    bus.rd_en = 1'b1; bus.rd_addr = '0;
    step();
    bus.rd_en = 1'b0;
    chk("idle_rd_ignored", 64'(bus.rd_valid), 64'd0);

    // K=512 counting pattern, a-priori on alternate cycles
    gen(512, 1'b0); cur_k = 512;
    send_blklen(512, 1'b0, 1'b1, "k512");
    chk("k512_len", 64'(bus.frame_len), 64'd512);
    load_frame(512, 1'b0, 2, 0, 1'b0, "load512");
    read_one(5, "k512_a5");
`ifndef SISO_FRAME_LOADER_SAT_EN
    chk("k512_a5_const", obs_rd(), {15'b0, 1'b1, 16'd10, 16'd11, 16'd1005});
    read_one(513, "k512_a513");
    chk("k512_a513_const", obs_rd(), {15'b0, 1'b1, 16'd1026, 16'd1027, 16'd0});
`endif
    read_one(514, "k512_a514");
    read_one(515, "k512_oor");
    read_one(8191, "k512_maxaddr");

    // overrun while FULL: samples dropped, RAM unchanged
    for (int i = 0; i < 3; i++) begin
      bus.valid_in = 1'b1; bus.in = 16'sh7777;
      step();
      chk($sformatf("overrun_%0d", i), 64'(bus.err_overrun), 64'd1);
    end
    bus.valid_in = 1'b0;
    step();
    chk("overrun_clear", 64'(bus.err_overrun), 64'd0);
    read_one(0, "overrun_a0");
    read_one(1, "overrun_a1");
    send_blklen(1056, 1'b1, 1'b1, "blk_in_full");

    // release with a read in the same cycle
    bus.release_req = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(5);
    step();
    bus.release_req = 1'b0; bus.rd_en = 1'b0;
    chk("rel_read", obs_rd(), exp_rd(5));
    chk("rel_busy", 64'(bus.busy), 64'd0);
    step();
    chk("rel_read_done", 64'(bus.rd_valid), 64'd0);

    // block length table
    send_blklen(513, 1'b1, 1'b0, "k513");
    send_blklen(6208, 1'b1, 1'b0, "k6208");
    send_blklen(32, 1'b1, 1'b0, "k32");
    for (int i = 0; i < 8; i++) begin
      k = (i < 4) ? 8 * $urandom_range(800, 0) : $urandom_range(7000, 0);
      lg = legal_k(k);
      send_blklen(k, !lg, lg, $sformatf("krand%0d_%0d", i, k));
      if (lg) begin
        rst = 1'b1; step(); rst = 1'b0;
        chk("krand_rst", obs_status(), 64'd0);
      end
    end

    // samples in IDLE are dropped silently
    bus.valid_in = 1'b1; bus.in = 16'sh1234;
    bus.valid_apriori = 1'b1; bus.apriori = 16'sh4321;
    step(); step();
    bus.valid_in = 1'b0; bus.valid_apriori = 1'b0;
    chk("idle_drop_overrun", 64'(bus.err_overrun), 64'd0);

    // K=1056 random, a-priori leading with surplus a-priori samples
    gen(1056, 1'b1); cur_k = 1056;
    send_blklen(1056, 1'b0, 1'b1, "k1056");
    load_frame(1056, 1'b1, 1, 0, 1'b1, "load1056");
    read_rand(40, "k1056_rd");
    bus.release_req = 1'b1; bus.valid_blklen = 1'b1; bus.blklen = 16'd40;
    step();
    bus.release_req = 1'b0; bus.valid_blklen = 1'b0;
    chk("relblk_err", 64'(bus.err_blklen), 64'd1);
    chk("relblk_busy", 64'(bus.busy), 64'd0);
    step();
    chk("relblk_idle", 64'(bus.busy), 64'd0);

    // K=6144 full frame, back-to-back read of every address
    gen(6144, 1'b1); cur_k = 6144;
    send_blklen(6144, 1'b0, 1'b1, "k6144");
    load_frame(6144, 1'b0, 1, 0, 1'b0, "load6144");
    read_seq(0, 6146, "k6144_rd");
    release_frame("k6144_rel");

    // a-priori ends 200 cycles after the input stream
    gen(512, 1'b1); cur_k = 512;
    send_blklen(512, 1'b0, 1'b1, "lag512");
    load_frame(512, 1'b0, 1, 718, 1'b0, "loadlag");
    read_rand(20, "lag_rd");
    release_frame("lag_rel");

    // reset in the middle of a load, then a fresh small frame
    send_blklen(512, 1'b0, 1'b1, "mid512");
    for (int i = 0; i < 300; i++) begin
      bus.valid_in = 1'b1; bus.in = 16'($urandom);
      step();
    end
    bus.valid_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_status", obs_status(), 64'd0);
    chk("midrst_rd", obs_rd(), 64'd0);
    gen(40, 1'b1); cur_k = 40;
    send_blklen(40, 1'b0, 1'b1, "k40");
    load_frame(40, 1'b1, 1, 5, 1'b0, "load40");
    read_seq(0, 45, "k40_rd");
    release_frame("k40_rel");

`ifdef SISO_FRAME_LOADER_SAT_EN
    gen(40, 1'b1); cur_k = 40;
    src_in[0] = 16'sd300; src_in[1] = -16'sd300; src_apr[0] = -16'sd5;
    send_blklen(40, 1'b0, 1'b1, "sat40");
    load_frame(40, 1'b0, 1, 0, 1'b0, "loadsat");
    read_one(0, "sat_a0");
    chk("sat_a0_const", obs_rd(), {15'b0, 1'b1, 16'sd127, -16'sd128, -16'sd5});
    read_seq(1, 43, "sat_rd");
    release_frame("sat_rel");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
